// File: rtl/spec_video_pkg.sv
// Shared VRAM arbiter types: bus widths, arbiter state enum and wait-owner flag.
package spec_video_pkg;
  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 16;
  localparam int PIX_W   = 8;
  localparam int COL_W   = 3;

  typedef enum logic [2:0] {IDLE, VRD, CRD, CWR, WAIT, ACK} state_t;
  typedef enum logic {VID, CPU} owner_t;

  function automatic int lat_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction
endpackage

// File: rtl/spec_vram_latency_ctr.sv
// Memory read-latency down-counter: load on entering WAIT, done on the last wait clock.
module spec_vram_latency_ctr
  import spec_video_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);
  localparam int CW = lat_cnt_w(MEM_LAT);

  logic [CW-1:0] cnt;

  // Parks at zero once expired, so it never wraps between accesses.
  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= CW'(MEM_LAT);
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign done = (cnt == CW'(1));
endmodule

// File: rtl/spec_vram_arbiter.sv
// VRAM arbiter: raster fetch always wins, CPU takes the idle slots.
// Optional SPEC_COLOR_EN: CPU writes carry cpu_color instead of fixed white.
module spec_vram_arbiter
  import spec_video_pkg::*;
#(
  parameter int AW      = VRAM_AW,
  parameter int DW      = VRAM_DW,
  parameter int MEM_LAT = 1
) (
  input  logic          clkVid,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic [2:0]    cpu_color,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);
  state_t        state, state_n;
  owner_t        owner;
  logic          vid_pend;
  logic [AW-1:0] vaddr_q;
  logic          ctr_load, ctr_done;
  logic [DW-1:0] wr_word;
  logic          unused_color;

  spec_vram_latency_ctr #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk   (clkVid),
    .reset (reset),
    .load  (ctr_load),
    .done  (ctr_done)
  );

`ifdef SPEC_COLOR_EN
  logic [COL_W-1:0] color_q;

  always_ff @(posedge clkVid) begin
    if (reset)             color_q <= '0;
    else if (state == CWR) color_q <= cpu_color;
  end

  assign wr_word      = DW'({5'b0, cpu_color, cpu_wdata});
  assign unused_color = ^color_q;
`else
  assign wr_word      = DW'({8'h07, cpu_wdata});
  assign unused_color = ^cpu_color;
`endif

  // A strobe arriving this cycle counts as pending so an idle bus starts the fetch at once.
  always_comb begin
    state_n   = state;
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ctr_load  = 1'b0;
    case (state)
      IDLE: begin
        if (vid_pend || vid_req) state_n = VRD;
        else if (cpu_req)        state_n = cpu_we ? CWR : CRD;
      end
      VRD: begin
        mem_rd   = 1'b1;
        mem_addr = vaddr_q;
        ctr_load = 1'b1;
        state_n  = WAIT;
      end
      CRD: begin
        mem_rd   = 1'b1;
        mem_addr = cpu_addr;
        ctr_load = 1'b1;
        state_n  = WAIT;
      end
      CWR: begin
        mem_we    = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = wr_word;
        state_n   = ACK;
      end
      WAIT: if (ctr_done) state_n = (owner == VID) ? IDLE : ACK;
      ACK:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkVid) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= VID;
      vid_pend  <= 1'b0;
      vaddr_q   <= '0;
      vid_data  <= '0;
      vid_valid <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == VRD)      owner <= VID;
      else if (state == CRD) owner <= CPU;

      // A fresh strobe beats the clear, so a request landing in VRD is not lost.
      if (vid_req) begin
        vid_pend <= 1'b1;
        vaddr_q  <= vid_addr;
      end else if (state == VRD) begin
        vid_pend <= 1'b0;
      end

      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      if (state == WAIT && ctr_done) begin
        if (owner == VID) begin
          vid_data  <= mem_rdata;
          vid_valid <= 1'b1;
        end else begin
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
        end
      end
      if (state == CWR) cpu_ack <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spec_vram_arbiter.sv
// Bench for spec_vram_arbiter: directed timing scenarios plus randomized traffic
// against a word-level memory model.
module tb_spec_vram_arbiter;
  localparam int L = 1;

  logic        clkVid = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [2:0]  cpu_color;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd, mem_we;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clkVid = ~clkVid;

  spec_vram_arbiter #(.AW(14), .DW(16), .MEM_LAT(L)) dut (
    .clkVid(clkVid), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_color(cpu_color), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Memory: unwritten words hold a pattern derived from the address; one override slot.
  logic [15:0] arr   [0:16383];
  bit          wr_ok [0:16383];
  bit          pv    [0:L-1];
  logic [13:0] pa    [0:L-1];
  bit          ovr_en = 1'b0;
  logic [13:0] ovr_addr = '0;
  logic [15:0] ovr_data = '0;

  function automatic logic [15:0] base(input logic [13:0] a);
    return {2'b10, a} ^ 16'h1234;
  endfunction

  always @(posedge clkVid) begin
    for (int i = L - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    pv[0] <= mem_rd;
    pa[0] <= mem_addr;
    if (mem_we) begin
      arr[mem_addr]   <= mem_wdata;
      wr_ok[mem_addr] <= 1'b1;
    end
  end

  assign mem_rdata = !pv[L-1] ? 16'hDEAD :
                     (ovr_en && pa[L-1] == ovr_addr) ? ovr_data :
                     wr_ok[pa[L-1]] ? arr[pa[L-1]] : base(pa[L-1]);

  int n_rd = 0, n_we = 0, n_both = 0;
  always @(negedge clkVid) begin
    if (mem_rd) n_rd++;
    if (mem_we) n_we++;
    if (mem_rd && mem_we) n_both++;
  end

  // Expected memory contents as seen by the bench's own CPU writes.
  logic [15:0] exp_arr [0:16383];
  bit          exp_ok  [0:16383];

  function automatic logic [15:0] exp_word(input logic [13:0] a);
    return exp_ok[a] ? exp_arr[a] : base(a);
  endfunction

  function automatic logic [15:0] wword(input logic [7:0] b, input logic [2:0] c);
`ifdef SPEC_COLOR_EN
    return {5'b0, c, b};
`else
    return {8'h07, b};
`endif
  endfunction

  task automatic tick();
    @(posedge clkVid);
    #1;
  endtask

  task automatic idle_inputs();
    vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0;
    cpu_addr = '0; cpu_wdata = '0; cpu_color = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    @(negedge clkVid);
    total++;
    if ({vid_data, vid_valid, cpu_rdata, cpu_ack} !== 34'd0) begin
      bad++; $display("FAIL reset_outs got=%h exp=0", {vid_data, vid_valid, cpu_rdata, cpu_ack});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_rd, mem_we} !== 32'd0) begin
      bad++; $display("FAIL reset_mem got=%h exp=0", {mem_addr, mem_wdata, mem_rd, mem_we});
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_video_only();
    int nrd, rd_cyc, val_cyc;
    logic [13:0] rd_a;
    logic [15:0] vd;
    ovr_en = 1; ovr_addr = 14'h0155; ovr_data = 16'h0523;
    for (int rep = 0; rep < 3; rep++) begin
      nrd = 0; rd_cyc = -1; val_cyc = -1; rd_a = '0; vd = '0;
      vid_req = 1; vid_addr = 14'h0155;
      for (int k = 0; k < 8; k++) begin
        @(negedge clkVid);
        if (mem_rd) begin nrd++; rd_cyc = k; rd_a = mem_addr; end
        if (vid_valid) begin val_cyc = k; vd = vid_data; end
        tick();
        vid_req = 0;
      end
      total++;
      if (nrd != 1 || rd_cyc != 1 || rd_a !== 14'h0155) begin
        bad++; $display("FAIL vid_rd n=%0d cyc=%0d addr=%h exp n=1 cyc=1 addr=0155", nrd, rd_cyc, rd_a);
      end
      total++;
      if (val_cyc != 2 + L) begin
        bad++; $display("FAIL vid_latency got=%0d exp=%0d", val_cyc, 2 + L);
      end
      total++;
      if (vd !== 16'h0523 || vid_data !== 16'h0523) begin
        bad++; $display("FAIL vid_data got=%h held=%h exp=0523", vd, vid_data);
      end
    end
  endtask

  task automatic test_cpu_read();
    int nrd, nack, ack_cyc;
    logic [13:0] rd_a;
    logic [15:0] rd;
    ovr_en = 1; ovr_addr = 14'h3FFF; ovr_data = 16'hA5A5;
    nrd = 0; nack = 0; ack_cyc = -1; rd_a = '0; rd = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h3FFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clkVid);
      if (mem_rd) begin nrd++; rd_a = mem_addr; end
      if (cpu_ack) begin nack++; ack_cyc = k; rd = cpu_rdata; end
      tick();
      if (ack_cyc >= 0) cpu_req = 0;
    end
    total++;
    if (nrd != 1 || rd_a !== 14'h3FFF) begin
      bad++; $display("FAIL cpu_rd_strobe n=%0d addr=%h exp n=1 addr=3fff", nrd, rd_a);
    end
    total++;
    if (nack != 1 || ack_cyc != 2 + L) begin
      bad++; $display("FAIL cpu_ack n=%0d cyc=%0d exp n=1 cyc=%0d", nack, ack_cyc, 2 + L);
    end
    total++;
    if (rd !== 16'hA5A5 || cpu_rdata !== 16'hA5A5) begin
      bad++; $display("FAIL cpu_rdata got=%h held=%h exp=a5a5", rd, cpu_rdata);
    end
  endtask

  task automatic test_collision();
    int nrd, nwe, rd_cyc, we_cyc, ack_cyc, val_cyc;
    logic [13:0] we_a;
    logic [15:0] wd;
    ovr_en = 1; ovr_addr = 14'h0155; ovr_data = 16'h0523;
    nrd = 0; nwe = 0; rd_cyc = -1; we_cyc = -1; ack_cyc = -1; val_cyc = -1; we_a = '0; wd = '0;
    vid_req = 1; vid_addr = 14'h0155;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = 8'hFF; cpu_color = 3'b010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clkVid);
      if (mem_rd) begin nrd++; rd_cyc = k; end
      if (mem_we) begin nwe++; we_cyc = k; we_a = mem_addr; wd = mem_wdata; end
      if (cpu_ack) ack_cyc = k;
      if (vid_valid) val_cyc = k;
      tick();
      vid_req = 0;
      if (ack_cyc >= 0) cpu_req = 0;
    end
    total++;
    if (nrd != 1 || nwe != 1 || rd_cyc < 0 || we_cyc <= rd_cyc) begin
      bad++; $display("FAIL coll_order rd=%0d@%0d we=%0d@%0d exp video read before write", nrd, rd_cyc, nwe, we_cyc);
    end
    total++;
    if (we_a !== 14'h0010 || wd !== wword(8'hFF, 3'b010)) begin
      bad++; $display("FAIL coll_write addr=%h data=%h exp addr=0010 data=%h", we_a, wd, wword(8'hFF, 3'b010));
    end
    total++;
    if (ack_cyc < 0 || ack_cyc > 7 || val_cyc < 0 || val_cyc > 7) begin
      bad++; $display("FAIL coll_latency ack=%0d valid=%0d exp both in 1..7", ack_cyc, val_cyc);
    end
    total++;
    if (vid_data !== 16'h0523) begin
      bad++; $display("FAIL coll_vid_data got=%h exp=0523", vid_data);
    end
  endtask

  // CPU read issued, then two fetch strobes during it: only the newer address is fetched.
  task automatic test_inflight();
    int nrd, ack_cyc, vrd_cyc, val_cyc;
    logic [13:0] vrd_a;
    ovr_en = 1; ovr_addr = 14'h0155; ovr_data = 16'h0523;
    nrd = 0; ack_cyc = -1; vrd_cyc = -1; val_cyc = -1; vrd_a = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0300;
    for (int k = 0; k < 12; k++) begin
      @(negedge clkVid);
      if (mem_rd) begin
        nrd++;
        if (k > 1) begin vrd_cyc = k; vrd_a = mem_addr; end
      end
      if (cpu_ack) ack_cyc = k;
      if (vid_valid) val_cyc = k;
      tick();
      vid_req = (k == 0 || k == 1);
      vid_addr = (k == 0) ? 14'h0222 : 14'h0155;
      if (ack_cyc >= 0) cpu_req = 0;
    end
    total++;
    if (ack_cyc != 2 + L || cpu_rdata !== base(14'h0300)) begin
      bad++; $display("FAIL inflight_cpu ack=%0d data=%h exp ack=%0d data=%h", ack_cyc, cpu_rdata, 2 + L, base(14'h0300));
    end
    total++;
    if (nrd != 2 || vrd_a !== 14'h0155) begin
      bad++; $display("FAIL inflight_fetch n=%0d addr=%h exp n=2 addr=0155", nrd, vrd_a);
    end
    total++;
    if (vrd_cyc <= ack_cyc || vrd_cyc > ack_cyc + 2 || val_cyc < 0 || val_cyc - 1 > 7) begin
      bad++; $display("FAIL inflight_latency vrd=%0d valid=%0d ack=%0d exp vrd right after ack, valid<=8", vrd_cyc, val_cyc, ack_cyc);
    end
    total++;
    if (vid_data !== 16'h0523) begin
      bad++; $display("FAIL inflight_vid_data got=%h exp=0523", vid_data);
    end
  endtask

  task automatic test_color();
    int nack;
    logic [15:0] wd;
    nack = 0; wd = '0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0020; cpu_wdata = 8'h81; cpu_color = 3'b101;
    for (int k = 0; k < 6; k++) begin
      @(negedge clkVid);
      if (mem_we) wd = mem_wdata;
      if (cpu_ack) nack++;
      tick();
      if (nack > 0) cpu_req = 0;
    end
    total++;
`ifdef SPEC_COLOR_EN
    if (wd !== 16'h0581 || nack != 1) begin
      bad++; $display("FAIL color_write data=%h acks=%0d exp data=0581 acks=1", wd, nack);
    end
`else
    if (wd !== 16'h0781 || nack != 1) begin
      bad++; $display("FAIL color_write data=%h acks=%0d exp data=0781 acks=1", wd, nack);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int nack;
    logic [15:0] rd;
    nack = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0300;
    for (int k = 0; k < 8; k++) begin
      @(negedge clkVid);
      if (cpu_ack) nack++;
      if (k == 3) begin
        total++;
        if ({vid_data, vid_valid, cpu_rdata, cpu_ack, mem_addr, mem_wdata, mem_rd, mem_we} !== 66'd0) begin
          bad++; $display("FAIL abort_outs vid=%h cpu=%h addr=%h rd=%b exp all 0", vid_data, cpu_rdata, mem_addr, mem_rd);
        end
      end
      tick();
      if (k == 1) reset = 1;
      if (k == 2) begin reset = 0; cpu_req = 0; end
    end
    total++;
    if (nack != 0) begin
      bad++; $display("FAIL abort_ack got=%0d exp=0", nack);
    end
    nack = 0; rd = '0;
    cpu_req = 1; cpu_addr = 14'h0301;
    for (int k = 0; k < 10; k++) begin
      @(negedge clkVid);
      if (cpu_ack) begin nack++; rd = cpu_rdata; end
      tick();
      if (nack > 0) cpu_req = 0;
    end
    total++;
    if (nack != 1 || rd !== base(14'h0301)) begin
      bad++; $display("FAIL after_abort acks=%0d data=%h exp acks=1 data=%h", nack, rd, base(14'h0301));
    end
  endtask

  task automatic test_random();
    int rd0, we0, both0, cpu_rds, cpu_wrs;
    ovr_en = 0;
    rd0 = n_rd; we0 = n_we; both0 = n_both; cpu_rds = 0; cpu_wrs = 0;
    fork
      begin : video
        for (int i = 0; i < 12; i++) begin
          int gap, lat;
          logic [13:0] a;
          logic [15:0] d;
          bit got;
          gap = 8 + $urandom_range(0, 4);
          a = 14'h0200 + 14'($urandom_range(0, 15));
          got = 0; lat = -1; d = '0;
          vid_req = 1; vid_addr = a;
          for (int k = 0; k < gap; k++) begin
            @(negedge clkVid);
            if (vid_valid && !got) begin got = 1; lat = k; d = vid_data; end
            tick();
            vid_req = 0;
          end
          total++;
          if (!got || lat > 7) begin
            bad++; $display("FAIL rnd_vid_latency got=%0d exp<=7", lat);
          end
          total++;
          if (d !== base(a)) begin
            bad++; $display("FAIL rnd_vid_data addr=%h got=%h exp=%h", a, d, base(a));
          end
        end
      end
      begin : cpu
        for (int i = 0; i < 24; i++) begin
          logic [13:0] a;
          logic [7:0]  b;
          logic [2:0]  c;
          logic [15:0] rd;
          bit we, got;
          repeat ($urandom_range(0, 3)) tick();
          a = 14'h0100 + 14'($urandom_range(0, 15));
          we = 1'($urandom_range(0, 1));
          b = 8'($urandom); c = 3'($urandom);
          cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = b; cpu_color = c;
          got = 0; rd = '0;
          for (int k = 0; k < 20; k++) begin
            @(negedge clkVid);
            if (cpu_ack) begin got = 1; rd = cpu_rdata; end
            tick();
            if (got) break;
          end
          cpu_req = 0;
          total++;
          if (!got) begin
            bad++; $display("FAIL rnd_cpu_timeout addr=%h we=%b", a, we);
          end else if (we) begin
            cpu_wrs++;
            exp_arr[a] = wword(b, c); exp_ok[a] = 1;
          end else begin
            cpu_rds++;
            if (rd !== exp_word(a)) begin
              bad++; $display("FAIL rnd_cpu_rdata addr=%h got=%h exp=%h", a, rd, exp_word(a));
            end
          end
        end
      end
    join
    tick(); tick();
    total++;
    if (n_rd - rd0 != 12 + cpu_rds || n_we - we0 != cpu_wrs || n_both != both0) begin
      bad++; $display("FAIL rnd_strobes rd=%0d we=%0d both=%0d exp rd=%0d we=%0d both=0",
                      n_rd - rd0, n_we - we0, n_both - both0, 12 + cpu_rds, cpu_wrs);
    end
  endtask

  initial begin
    test_reset();
    test_video_only();
    test_cpu_read();
    test_collision();
    test_inflight();
    test_color();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
